// File: rtl/apb_stream_fifo.sv
// APB slave bridging register accesses to a TX and an RX fall-through stream
// FIFO, with level/status registers, sticky error flags and a threshold irq.

module apb_stream_fifo_buf #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             pclk,
   input  logic             reset,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     wdata,
   output logic [W-1:0]     rdata,
   output logic [LVL_W-1:0] level,
   output logic             empty,
   output logic             full
);
   localparam int PTR_W = LVL_W - 1;

   logic [W-1:0]     mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [LVL_W-1:0] level_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign empty     = (level_r == LVL_W'(1'b0));
   assign full      = (level_r == LVL_W'(DEPTH));
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign rdata     = mem_r[rd_ptr_r];
   assign level     = level_r;

   // Pointer and occupancy tracking; a clear overrides same-cycle push/pop
   always_ff @(posedge pclk) begin
      if (reset || clr) begin
         wr_ptr_r <= PTR_W'(1'b0);
         rd_ptr_r <= PTR_W'(1'b0);
         level_r  <= LVL_W'(1'b0);
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         case ({push_ok_s, pop_ok_s})
            2'b10:   level_r <= level_r + LVL_W'(1'b1);
            2'b01:   level_r <= level_r - LVL_W'(1'b1);
            default: level_r <= level_r;
         endcase
      end
   end

   // Storage write; contents are not reset
   always_ff @(posedge pclk) begin
      if (push_ok_s && !clr && !reset) mem_r[wr_ptr_r] <= wdata;
   end
endmodule

module apb_stream_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ERR_EN = 1
) (
   input  logic              pclk,
   input  logic              reset,
   input  logic [3:0]        paddr,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              irq
);
   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam logic [1:0] A_DATA  = 2'd0;
   localparam logic [1:0] A_STAT  = 2'd1;
   localparam logic [1:0] A_LEVEL = 2'd2;
   localparam logic [1:0] A_CFG   = 2'd3;

   logic              setup_s, access_s;
   logic [1:0]        word_s;
   logic              wr_data_s, wr_ctrl_s, wr_cfg_s, rd_data_s, bad_s;
   logic              ovf_s, unf_s, irq_nxt_s;
   logic              tx_push_s, tx_pop_s, tx_clr_s;
   logic              rx_push_s, rx_pop_s, rx_clr_s, sticky_clr_s;
   logic [DATA_W-1:0] tx_head_s, rx_head_s;
   logic [LVL_W-1:0]  tx_level_s, rx_level_s;
   logic              tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
   logic [31:0]       rd_mux_s;
   logic [31:0]       prdata_r;
   logic              rd_empty_r, tx_ovf_r, rx_unf_r, irq_r, err_irq_en_r;
   logic [15:0]       rx_thresh_r;
   logic              unused_s;

   assign setup_s  = psel & ~penable;
   assign access_s = psel & penable;
   assign word_s   = paddr[3:2];
   assign unused_s = ^{paddr[1:0], pwdata[31:17]};

   // Access-phase decode of APB side effects
   always_comb begin
      wr_data_s = 1'b0;
      wr_ctrl_s = 1'b0;
      wr_cfg_s  = 1'b0;
      rd_data_s = 1'b0;
      bad_s     = 1'b0;
      if (access_s) begin
         if (pwrite) begin
            case (word_s)
               A_DATA:  wr_data_s = 1'b1;
               A_STAT:  wr_ctrl_s = 1'b1;
               A_CFG:   wr_cfg_s  = 1'b1;
               default: bad_s     = 1'b1;
            endcase
         end else begin
            rd_data_s = (word_s == A_DATA);
         end
      end else begin
         bad_s = 1'b0;
      end
   end

   // Full/empty here are the pre-edge state, so a same-cycle stream pop cannot admit a write
   assign ovf_s        = wr_data_s & tx_full_s;
   assign unf_s        = rd_data_s & rd_empty_r;
   assign tx_push_s    = wr_data_s & ~tx_full_s;
   assign tx_pop_s     = m_valid & m_ready;
   assign tx_clr_s     = wr_ctrl_s & pwdata[0];
   assign rx_clr_s     = wr_ctrl_s & pwdata[1];
   assign sticky_clr_s = wr_ctrl_s & pwdata[2];
   assign rx_push_s    = s_valid & s_ready;
   assign rx_pop_s     = rd_data_s & ~rd_empty_r;

   apb_stream_fifo_buf #(.W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_tx (
      .pclk(pclk), .reset(reset), .clr(tx_clr_s), .push(tx_push_s), .pop(tx_pop_s),
      .wdata(pwdata[DATA_W-1:0]), .rdata(tx_head_s), .level(tx_level_s),
      .empty(tx_empty_s), .full(tx_full_s)
   );

   apb_stream_fifo_buf #(.W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_rx (
      .pclk(pclk), .reset(reset), .clr(rx_clr_s), .push(rx_push_s), .pop(rx_pop_s),
      .wdata(s_data), .rdata(rx_head_s), .level(rx_level_s),
      .empty(rx_empty_s), .full(rx_full_s)
   );

   // Register read multiplexer
   always_comb begin
      rd_mux_s = 32'd0;
      case (word_s)
         A_DATA:  rd_mux_s = rx_empty_s ? 32'd0 : 32'(rx_head_s);
         A_STAT:  rd_mux_s = {25'd0, irq_r, rx_unf_r, tx_ovf_r,
                              tx_full_s, tx_empty_s, rx_full_s, rx_empty_s};
         A_LEVEL: rd_mux_s = {16'(tx_level_s), 16'(rx_level_s)};
         A_CFG:   rd_mux_s = {15'd0, err_irq_en_r, rx_thresh_r};
         default: rd_mux_s = 32'd0;
      endcase
   end

   // Read data captured at setup and held through access; zero in every other cycle
   always_ff @(posedge pclk) begin
      if (reset) begin
         prdata_r   <= 32'd0;
         rd_empty_r <= 1'b1;
      end else if (setup_s && !pwrite) begin
         prdata_r   <= rd_mux_s;
         rd_empty_r <= rx_empty_s;
      end else begin
         prdata_r   <= 32'd0;
      end
   end

   assign irq_nxt_s = ((rx_thresh_r != 16'd0) && (32'(rx_level_s) >= 32'(rx_thresh_r)))
                    | (err_irq_en_r & (tx_ovf_r | rx_unf_r));

   // Sticky flags (clear wins over set), irq configuration and the irq register
   always_ff @(posedge pclk) begin
      if (reset) begin
         tx_ovf_r     <= 1'b0;
         rx_unf_r     <= 1'b0;
         rx_thresh_r  <= 16'd0;
         err_irq_en_r <= 1'b0;
         irq_r        <= 1'b0;
      end else begin
         if (sticky_clr_s) begin
            tx_ovf_r <= 1'b0;
            rx_unf_r <= 1'b0;
         end else begin
            if (ovf_s) tx_ovf_r <= 1'b1;
            if (unf_s) rx_unf_r <= 1'b1;
         end
         if (wr_cfg_s) begin
            rx_thresh_r  <= pwdata[15:0];
            err_irq_en_r <= pwdata[16];
         end
         irq_r <= irq_nxt_s;
      end
   end

   assign prdata  = prdata_r;
   assign pready  = 1'b1;
   assign pslverr = (ERR_EN != 0) ? (~reset & (ovf_s | unf_s | bad_s)) : 1'b0;
   assign m_data  = tx_head_s;
   assign m_valid = ~tx_empty_s;
   assign s_ready = ~rx_full_s;
   assign irq     = irq_r;
endmodule

// File: tb/tb_apb_stream_fifo.sv
// Scoreboard bench for apb_stream_fifo (DATA_W=8, DEPTH=4, ERR_EN=1).

module tb_apb_stream_fifo;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;

   logic              pclk = 1'b0;
   logic              reset;
   logic [3:0]        paddr;
   logic              psel, penable, pwrite;
   logic [31:0]       pwdata, prdata;
   logic              pready, pslverr;
   logic [DATA_W-1:0] m_data, s_data;
   logic              m_valid, m_ready, s_valid, s_ready, irq;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [7:0] tx_exp_q[$];
   logic [7:0] rx_exp_q[$];
   int tx_cnt = 0;
   int rx_cnt = 0;

   always #5 pclk = ~pclk;

   apb_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ERR_EN(1)) dut (
      .pclk(pclk), .reset(reset), .paddr(paddr), .psel(psel), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .irq(irq)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic apb_write(input logic [3:0] a, input logic [31:0] d, output logic err);
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(posedge pclk); #1;
      penable = 1'b1;
      #1 err = pslverr;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic err);
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(posedge pclk); #1;
      penable = 1'b1;
      #1 d = prdata; err = pslverr;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic        e;
      apb_read(a, d, e);
      check_eq(tag, d, exp);
   endtask

   task automatic tx_write(input logic [7:0] d);
      logic e;
      logic exp_e;
      exp_e = (tx_cnt == DEPTH);
      apb_write(4'h0, {24'd0, d}, e);
      check_eq("tx_wr_err", 32'(e), 32'(exp_e));
      if (!exp_e) begin
         tx_exp_q.push_back(d);
         tx_cnt++;
      end
   endtask

   task automatic tx_drain(input int n);
      logic [7:0] exp;
      m_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         #1;
         check_eq("m_valid_drain", 32'(m_valid), 32'd1);
         if (tx_exp_q.size() == 0) begin
            check_eq("tx_q_size", 32'd0, 32'd1);
         end else begin
            exp = tx_exp_q.pop_front();
            check_eq("m_data", 32'(m_data), 32'(exp));
            tx_cnt--;
         end
         @(posedge pclk); #1;
      end
      m_ready = 1'b0;
      #1 check_eq("m_valid_after", 32'(m_valid), 32'(tx_cnt != 0));
   endtask

   task automatic rx_push(input logic [7:0] d);
      logic acc;
      acc = (rx_cnt < DEPTH);
      @(posedge pclk); #1;
      s_valid = 1'b1; s_data = d;
      #1 check_eq("s_ready", 32'(s_ready), 32'(acc));
      @(posedge pclk); #1;
      s_valid = 1'b0;
      if (acc) begin
         rx_exp_q.push_back(d);
         rx_cnt++;
      end
   endtask

   task automatic rx_read();
      logic [31:0] d;
      logic [31:0] exp_d;
      logic        e;
      logic        exp_e;
      exp_e = (rx_cnt == 0);
      exp_d = 32'd0;
      if (!exp_e) begin
         exp_d = 32'(rx_exp_q.pop_front());
         rx_cnt--;
      end
      apb_read(4'h0, d, e);
      check_eq("rx_rd_data", d, exp_d);
      check_eq("rx_rd_err", 32'(e), 32'(exp_e));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        er;
      logic [7:0]  b;
      reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 4'h0; pwdata = 32'd0; m_ready = 1'b0; s_valid = 1'b0; s_data = 8'd0;
      repeat (3) @(posedge pclk);
      #1 reset = 1'b0;

      // reset state
      check_eq("rst_m_valid", 32'(m_valid), 32'd0);
      check_eq("rst_s_ready", 32'(s_ready), 32'd1);
      check_eq("rst_irq", 32'(irq), 32'd0);
      check_eq("rst_pslverr", 32'(pslverr), 32'd0);
      check_eq("rst_prdata", prdata, 32'd0);
      read_chk("rst_status", 4'h4, 32'h05);
      #1 check_eq("prdata_idle", prdata, 32'd0);
      read_chk("rst_level", 4'h8, 32'h0);

      // TX fill, overflow, undecoded write, drain
      tx_write(8'h11); tx_write(8'h22); tx_write(8'h33); tx_write(8'h44);
      read_chk("tx_full_status", 4'h4, 32'h09);
      read_chk("tx_full_level", 4'h8, 32'h0004_0000);
      tx_write(8'h55);
      read_chk("tx_ovf_status", 4'h4, 32'h19);
      apb_write(4'h8, 32'hFFFF_FFFF, er);
      check_eq("level_wr_err", 32'(er), 32'd1);
      read_chk("level_after_wr", 4'h8, 32'h0004_0000);
      tx_drain(4);

      // RX stream in and APB pops, underflow
      rx_push(8'hA5); rx_push(8'h5A);
      read_chk("rx_level2", 4'h8, 32'h2);
      rx_read(); rx_read(); rx_read();

      // A push landing on the setup edge does not rescue an empty read
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0;
      s_valid = 1'b1; s_data = 8'h99;
      @(posedge pclk); #1;
      s_valid = 1'b0; penable = 1'b1;
      #1 check_eq("unf_race_data", prdata, 32'd0);
      check_eq("unf_race_err", 32'(pslverr), 32'd1);
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      rx_exp_q.push_back(8'h99); rx_cnt++;
      read_chk("sticky_status", 4'h4, 32'h34);
      rx_read();
      apb_write(4'h4, 32'h4, er);
      read_chk("sticky_cleared", 4'h4, 32'h05);

      // Level-threshold interrupt
      apb_write(4'hC, 32'h2, er);
      check_eq("cfg_wr_err", 32'(er), 32'd0);
      read_chk("cfg_read", 4'hC, 32'h2);
      rx_push(8'h01);
      rx_push(8'h02);
      check_eq("irq_lat0", 32'(irq), 32'd0);
      @(posedge pclk); #1;
      check_eq("irq_rise", 32'(irq), 32'd1);
      rx_read();
      check_eq("irq_hold", 32'(irq), 32'd1);
      @(posedge pclk); #1;
      check_eq("irq_fall", 32'(irq), 32'd0);
      rx_read();

      // Error interrupt, sticky clear, TX clear
      apb_write(4'hC, 32'h0001_0000, er);
      tx_write(8'h71); tx_write(8'h72); tx_write(8'h73); tx_write(8'h74); tx_write(8'h75);
      @(posedge pclk); #1;
      check_eq("err_irq", 32'(irq), 32'd1);
      apb_write(4'h4, 32'h4, er);
      @(posedge pclk); #1;
      check_eq("err_irq_clr", 32'(irq), 32'd0);
      read_chk("flags_clr_status", 4'h4, 32'h09);
      apb_write(4'h4, 32'h1, er);
      tx_exp_q.delete(); tx_cnt = 0;
      #1 check_eq("tx_clr_m_valid", 32'(m_valid), 32'd0);
      read_chk("tx_clr_status", 4'h4, 32'h05);
      apb_write(4'hC, 32'h0, er);

      // RX fill to full; s_ready drops only at level DEPTH
      for (int i = 0; i < DEPTH + 1; i++) rx_push(8'hC0 + 8'(i));
      check_eq("rx_full_s_ready", 32'(s_ready), 32'd0);
      read_chk("rx_full_level", 4'h8, 32'h4);
      for (int i = 0; i < DEPTH; i++) rx_read();

      // RX clear in the same cycle as a stream push
      @(posedge pclk); #1;
      s_valid = 1'b1; s_data = 8'h61;
      @(posedge pclk); #1;
      s_data = 8'h62;
      @(posedge pclk); #1;
      s_data = 8'h63;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h4; pwdata = 32'h2;
      @(posedge pclk); #1;
      s_data = 8'h64; penable = 1'b1;
      #1 check_eq("clr_race_s_ready", 32'(s_ready), 32'd1);
      @(posedge pclk); #1;
      s_valid = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      read_chk("clr_race_level", 4'h8, 32'h0);
      read_chk("clr_race_status", 4'h4, 32'h05);

      // Pointer wrap with data integrity on both FIFOs
      for (int i = 0; i < DEPTH * 3; i++) begin
         b = 8'($urandom_range(0, 255));
         rx_push(b);
         rx_read();
         tx_write(b ^ 8'hFF);
         tx_drain(1);
      end

      // Reset during an APB write access phase
      apb_write(4'hC, 32'h1, er);
      rx_push(8'h42);
      @(posedge pclk); #1;
      check_eq("pre_rst_irq", 32'(irq), 32'd1);
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h0; pwdata = 32'h77;
      @(posedge pclk); #1;
      penable = 1'b1; reset = 1'b1;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(posedge pclk); #1;
      reset = 1'b0;
      rx_exp_q.delete(); rx_cnt = 0;
      check_eq("mid_rst_m_valid", 32'(m_valid), 32'd0);
      check_eq("mid_rst_s_ready", 32'(s_ready), 32'd1);
      check_eq("mid_rst_irq", 32'(irq), 32'd0);
      check_eq("mid_rst_pslverr", 32'(pslverr), 32'd0);
      check_eq("mid_rst_prdata", prdata, 32'd0);
      read_chk("mid_rst_status", 4'h4, 32'h05);
      read_chk("mid_rst_level", 4'h8, 32'h0);
      read_chk("mid_rst_cfg", 4'hC, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
